branch_resolve_ctrl: RTL
========================

// Module: branch_resolve_ctrl
// PURPOSE
//  Sequences branch resolution in the ID stage of the 16-bit pipeline. Holds the branch while its operands
//  are not yet forwarded, drives the shared comparator (mode 00 eq, 01 gt, 10 lt, 11 never), and checks the
//  result against the fetch-time prediction. On a mispredict it flushes and redirects IF/ID.
//  Owns a 2-bit saturating branch history table (BHT) that IF reads every cycle.
// PARAMETERS
//  IDX_W        4   BHT index width; table has 2**IDX_W entries, index = pc[IDX_W-1:0]
//  FLUSH_CYCLES 1   cycles flush is held after a mispredict, range 1..3
//  PC_INC       1   fall-through increment, word addressed
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  if_pc          in   16  fetch PC used for BHT lookup
//  if_pred_taken  out  1   combinational: BHT[if_pc idx][1]
//  br_valid       in   1   branch instruction present in ID
//  br_pred_taken  in   1   prediction carried with the branch from IF
//  br_mode        in   2   compare mode
//  br_pc          in   16  PC of the branch
//  br_target      in   16  taken target
//  ops_ready      in   1   forwarding unit reports opA/opB valid
//  opA, opB       in   16  branch operands
//  cmp_a, cmp_b   out  16  to comparator: captured operands
//  cmp_mode       out  2   to comparator: captured mode
//  cmp_out        in   1   comparator result, combinational from cmp_*
//  stall          out  1   freeze PC and IF/ID
//  flush          out  1   squash IF/ID contents
//  redirect_valid out  1   one-cycle pulse: load redirect_pc into PC
//  redirect_pc    out  16  corrected PC
//  br_count       out  16  resolved branches, saturates at 16'hFFFF
//  mispred_count  out  16  mispredicts, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs, capture registers and counters are 0; every BHT entry is 2'b01.
//  Reset mid-operation aborts any pending flush or redirect.
//  FSM states:
//   IDLE:    on br_valid, capture pc, target, mode, and pred. If ops_ready, also capture opA/opB and
//            go to RESOLVE; otherwise go to WAIT_OPS. br_valid is ignored in every other state.
//   WAIT_OPS: stall=1. On ops_ready, capture opA/opB and go to RESOLVE.
//   RESOLVE:  one cycle, stall=1.
//            taken = cmp_out & (mode!=2'b11); mispred = taken ^ pred.
//            br_count increments.
//            BHT[pc idx] moves toward taken, saturating at 00 and 11.
//            If mispred: mispred_count increments, and on the next edge redirect_valid=1 for one cycle
//            with redirect_pc = taken ? target : pc+PC_INC (mod 2**16); go to FLUSH.
//            Otherwise go to IDLE.
//   FLUSH:    flush=1 and stall=1 for FLUSH_CYCLES cycles (down-counter), then go to IDLE.
//  Latency: with ops_ready at br_valid, stall rises the cycle after capture and lasts 1 cycle (correct
//   prediction) or 1+FLUSH_CYCLES cycles (mispredict). The redirect pulse is coincident with the first
//   flush cycle.
//  stall, flush, and redirect_valid are registered from FSM state, not combinational on inputs.
//  cmp_a, cmp_b and cmp_mode hold their last captured values outside RESOLVE.
//  BHT write on the same cycle and index as an IF lookup: the lookup returns the pre-update value.
//  Counter behaviour: at 16'hFFFF a counter holds. br_count and mispred_count never wrap.
//  mode 2'b11 is always not-taken. If pred=1 for such a branch, it resolves as a mispredict to pc+PC_INC.
// TESTING
//  T1: reset; read if_pred_taken for idx 0..15 -> all 0; the BHT read back via lookups is 01 everywhere.
//  T2: br pc=0x0005, target=0x0040, mode=00, A=B=0x1234, pred=0, ops_ready=1 -> cmp_out=1, mispred,
//      redirect_pc=0x0040 pulse, flush 1 cycle, BHT[5]=10, mispred_count=1.
//  T3: br pc=0x0007, mode=01, A=3, B=9, pred=0, ops_ready low for 3 cycles -> stall high for 3 cycles
//      in WAIT_OPS plus the RESOLVE cycle; no flush; br_count increments.
//  T4: br pc=0x00FF, mode=10, A=9, B=3, pred=1 -> not taken, redirect_pc=0x0100; BHT[15] saturates at 00
//      after two repeats.
//  T5: FLUSH_CYCLES=3, mispredict -> flush high exactly 3 cycles; br_valid during FLUSH is ignored.
//  T6: assert rst during WAIT_OPS and during FLUSH -> stall, flush and redirect drop immediately;
//      counters clear; FSM returns to IDLE.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl
//
// Resolves conditional branches in the ID stage of the 16-bit pipeline.
// A branch arriving in ID is captured along with its fetch-time prediction.
// If the forwarding unit has not yet produced the operands, the branch is held
// and the pipeline is stalled. Once the operands are ready, they are latched
// and presented to the shared comparator. The comparator result is then checked
// against the prediction. A mispredict squashes IF/ID for FLUSH_CYCLES cycles
// and pulses a redirect to the corrected PC.
//
// The block also owns the 2-bit saturating branch history table that IF
// consults every cycle for its prediction.
//
// Parameters
//   IDX_W         BHT index width (2**IDX_W entries, index = pc[IDX_W-1:0])
//   FLUSH_CYCLES  cycles flush is held after a mispredict (1..3)
//   PC_INC        fall-through increment (word addressed)
//
// Ports
//   clk, rst                  clock and asynchronous active-high reset
//   if_pc / if_pred_taken     IF-side BHT lookup (combinational read)
//   br_valid, br_pred_taken,
//   br_mode, br_pc, br_target branch presented by ID
//   ops_ready, opA, opB       operands from the forwarding unit
//   cmp_a, cmp_b, cmp_mode    captured operands/mode to the comparator
//   cmp_out                   comparator result
//   stall, flush              pipeline control, decoded from FSM state only
//   redirect_valid/_pc        one-cycle PC correction pulse
//   br_count, mispred_count   saturating statistics counters
// -----------------------------------------------------------------------------
module branch_resolve_ctrl #(
  parameter int          IDX_W        = 4,
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [15:0] PC_INC       = 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] if_pc,
  output logic        if_pred_taken,
  input  logic        br_valid,
  input  logic        br_pred_taken,
  input  logic [1:0]  br_mode,
  input  logic [15:0] br_pc,
  input  logic [15:0] br_target,
  input  logic        ops_ready,
  input  logic [15:0] opA,
  input  logic [15:0] opB,
  output logic [15:0] cmp_a,
  output logic [15:0] cmp_b,
  output logic [1:0]  cmp_mode,
  input  logic        cmp_out,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [15:0] redirect_pc,
  output logic [15:0] br_count,
  output logic [15:0] mispred_count
);

  localparam int         BHT_DEPTH  = 1 << IDX_W;
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OPS = 2'd1,
    RESOLVE  = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [15:0]      pc_q;
  logic [15:0]      target_q;
  logic             pred_q;
  logic [1:0]       flush_cnt;
  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] br_idx;
  logic [IDX_W-1:0] if_idx;
  logic             taken;
  logic             mispred;
  logic             capture_br;
  logic             capture_ops;
  logic             unused_if_pc;

  // The upper fetch PC bits do not take part in the lookup; they are folded
  // into a dummy signal so the intent is visible.
  assign unused_if_pc = ^if_pc;

  // Table indices come from the low PC bits. IF reads the table
  // combinationally, so a write in the same cycle to the same entry is
  // only visible to IF from the next cycle onward.
  assign br_idx        = pc_q[IDX_W-1:0];
  assign if_idx        = if_pc[IDX_W-1:0];
  assign if_pred_taken = bht[if_idx][1];

  // Mode 11 means "never taken", regardless of what the comparator reports.
  // Any disagreement with the carried prediction is a mispredict.
  assign taken   = cmp_out & (cmp_mode != 2'b11);
  assign mispred = taken ^ pred_q;

  // State register. Reset drops the FSM straight back to IDLE, so any
  // stall or flush in progress is abandoned immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode. stall and flush depend only on the
  // registered state, never on this cycle's inputs, which keeps them
  // glitch-free toward the PC and IF/ID enables. A new branch is only
  // accepted in IDLE; br_valid in any other state is ignored.
  always_comb begin
    next_state  = state;
    stall       = 1'b0;
    flush       = 1'b0;
    capture_br  = 1'b0;
    capture_ops = 1'b0;
    case (state)
      IDLE: begin
        if (br_valid) begin
          capture_br = 1'b1;
          if (ops_ready) begin
            capture_ops = 1'b1;
            next_state  = RESOLVE;
          end else begin
            next_state = WAIT_OPS;
          end
        end
      end
      WAIT_OPS: begin
        stall = 1'b1;
        if (ops_ready) begin
          capture_ops = 1'b1;
          next_state  = RESOLVE;
        end
      end
      RESOLVE: begin
        stall      = 1'b1;
        next_state = mispred ? FLUSH : IDLE;
      end
      FLUSH: begin
        stall = 1'b1;
        flush = 1'b1;
        if (flush_cnt == 2'd0) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Capture registers. The branch descriptor is latched on acceptance. The
  // operands are latched when the forwarding unit declares them valid. These
  // operands may arrive later than the descriptor. The comparator inputs hold
  // their last values outside RESOLVE, so the comparator does not toggle
  // needlessly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= 16'd0;
      target_q <= 16'd0;
      pred_q   <= 1'b0;
      cmp_mode <= 2'b00;
      cmp_a    <= 16'd0;
      cmp_b    <= 16'd0;
    end else begin
      if (capture_br) begin
        pc_q     <= br_pc;
        target_q <= br_target;
        pred_q   <= br_pred_taken;
        cmp_mode <= br_mode;
      end
      if (capture_ops) begin
        cmp_a <= opA;
        cmp_b <= opB;
      end
    end
  end

  // Flush down-counter. It is loaded while leaving RESOLVE, so the FLUSH
  // state lasts exactly FLUSH_CYCLES cycles and exits when the count hits
  // zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= 2'd0;
    end else if (state == RESOLVE) begin
      flush_cnt <= FLUSH_LOAD;
    end else if (state == FLUSH && flush_cnt != 2'd0) begin
      flush_cnt <= flush_cnt - 2'd1;
    end
  end

  // Redirect pulse. It is registered out of RESOLVE, so it coincides with
  // the first flush cycle. The fall-through address wraps naturally at
  // 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= 16'd0;
    end else begin
      redirect_valid <= (state == RESOLVE) && mispred;
      if (state == RESOLVE && mispred) begin
        redirect_pc <= taken ? target_q : (pc_q + PC_INC);
      end
    end
  end

  // Statistics. Each counter freezes at all-ones rather than wrapping, so a
  // saturated value is never misread as a small count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count      <= 16'd0;
      mispred_count <= 16'd0;
    end else if (state == RESOLVE) begin
      if (br_count != 16'hFFFF) begin
        br_count <= br_count + 16'd1;
      end
      if (mispred && mispred_count != 16'hFFFF) begin
        mispred_count <= mispred_count + 16'd1;
      end
    end
  end

  // Branch history table. Every entry starts weakly not-taken (01). The
  // resolved branch nudges its entry one step toward the actual outcome,
  // saturating at 00 and 11.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (state == RESOLVE) begin
      if (taken) begin
        if (bht[br_idx] != 2'b11) begin
          bht[br_idx] <= bht[br_idx] + 2'b01;
        end
      end else begin
        if (bht[br_idx] != 2'b00) begin
          bht[br_idx] <= bht[br_idx] - 2'b01;
        end
      end
    end
  end

endmodule
